// File: rtl/rocstar_ts_pkg.sv
// Shared tags and constants for the rocstar coincidence timestamp block.
package rocstar_ts_pkg;

    typedef logic [1:0] tag_t;

    localparam tag_t TAG_SYNC = 2'b00;
    localparam tag_t TAG_P    = 2'b01;
    localparam tag_t TAG_D    = 2'b10;
    localparam tag_t TAG_N    = 2'b11;

    localparam logic [15:0] SAT16 = 16'hFFFF;

    // Saturating add of a small increment (0..3) to a 16-bit counter.
    function automatic logic [15:0] sat_add16(input logic [15:0] v, input logic [1:0] inc);
        logic [16:0] s;
        s = {1'b0, v} + {15'd0, inc};
        return s[16] ? SAT16 : s[15:0];
    endfunction

endpackage

// File: rtl/ts_fifo.sv
// Synchronous FIFO with registered read port; clear flushes contents synchronously.
module ts_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 50
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       rvalid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic [WIDTH-1:0] rdata_q;
    logic             rvalid_q;
    logic             pop_ok, push_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign pop_ok  = pop & ~empty & ~clear;
    // A pop in the same cycle frees the slot, so a push while full still lands.
    assign push_ok = push & (~full | pop_ok) & ~clear;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= pop_ok;
            if (clear) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop_ok) begin
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                    rdata_q  <= mem[rd_ptr_q];
                end
                if (push_ok && !pop_ok)      count_q <= count_q + (AW+1)'(1);
                else if (pop_ok && !push_ok) count_q <= count_q - (AW+1)'(1);
            end
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign count  = count_q;

endmodule

// File: rtl/rocstar_coinc_timestamp.sv
// Clock counter, save register and coincidence timestamp FIFO.
// Optional ROCSTAR_TS_SYNCSTAMP_EN: each sync_clk also pushes a tag-00 entry.
module rocstar_coinc_timestamp
    import rocstar_ts_pkg::*;
#(
    parameter int unsigned CNT_W = 48,
    parameter int unsigned DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    runmode,
    input  logic                    sync_clk,
    input  logic                    save_clk,
    input  logic                    pcoinc,
    input  logic                    dcoinc,
    input  logic                    ncoinc,
    input  logic                    clear,
    input  logic                    rd_en,
    output logic [CNT_W-1:0]        clkcnt,
    output logic [CNT_W-1:0]        clksav,
    output logic                    rd_valid,
    output logic [CNT_W+1:0]        rd_data,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic [15:0]             overflow_cnt,
    output logic [15:0]             multi_cnt
);
    localparam int unsigned DW = CNT_W + 2;

    logic [CNT_W-1:0] clkcnt_q, clksav_q;
    logic [15:0]      ovf_q, multi_q;
    tag_t             tag;
    logic             coinc_push, multi_hit, push, push_drop, sync_drop;
    logic             fifo_full, fifo_empty;
    logic [DW-1:0]    push_data;
    logic [1:0]       ovf_inc;

    always_comb begin
        tag = TAG_N;
        if (pcoinc)      tag = TAG_P;
        else if (dcoinc) tag = TAG_D;
    end

    assign coinc_push = runmode & (pcoinc | dcoinc | ncoinc);
    assign multi_hit  = runmode & ((pcoinc & dcoinc) | (pcoinc & ncoinc) | (dcoinc & ncoinc));

`ifdef ROCSTAR_TS_SYNCSTAMP_EN
    // The sync stamp wins the single push slot; a coincident flag is lost and counted.
    assign push      = sync_clk | coinc_push;
    assign push_data = sync_clk ? {TAG_SYNC, clkcnt_q} : {tag, clkcnt_q};
    assign sync_drop = sync_clk & coinc_push;
`else
    assign push      = coinc_push;
    assign push_data = {tag, clkcnt_q};
    assign sync_drop = 1'b0;
`endif

    assign push_drop = push & fifo_full & ~(rd_en & ~fifo_empty) & ~clear;
    assign ovf_inc   = {1'b0, push_drop} + {1'b0, sync_drop};

    ts_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DW)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (push),
        .pop    (rd_en),
        .clear  (clear),
        .wdata  (push_data),
        .rdata  (rd_data),
        .rvalid (rd_valid),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clkcnt_q <= '0;
            clksav_q <= '0;
            ovf_q    <= '0;
            multi_q  <= '0;
        end else begin
            clkcnt_q <= sync_clk ? '0 : clkcnt_q + CNT_W'(1);
            if (save_clk) clksav_q <= clkcnt_q;
            if (clear) begin
                ovf_q   <= '0;
                multi_q <= '0;
            end else begin
                ovf_q   <= sat_add16(ovf_q, ovf_inc);
                multi_q <= sat_add16(multi_q, {1'b0, multi_hit});
            end
        end
    end

    assign clkcnt       = clkcnt_q;
    assign clksav       = clksav_q;
    assign overflow_cnt = ovf_q;
    assign multi_cnt    = multi_q;

endmodule

// File: tb/tb_rocstar_coinc_timestamp.sv
// Self-checking bench for rocstar_coinc_timestamp against a queue-based reference model.
module tb_rocstar_coinc_timestamp;
    localparam int CW = 48;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic runmode = 0, sync_clk = 0, save_clk = 0, pcoinc = 0, dcoinc = 0, ncoinc = 0;
    logic clear = 0, rd_en = 0;
    logic [CW-1:0] clkcnt, clksav;
    logic          rd_valid;
    logic [CW+1:0] rd_data;
    logic [4:0]    fifo_count;
    logic [15:0]   overflow_cnt, multi_cnt;

    rocstar_coinc_timestamp #(.CNT_W(CW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .runmode(runmode), .sync_clk(sync_clk),
        .save_clk(save_clk), .pcoinc(pcoinc), .dcoinc(dcoinc), .ncoinc(ncoinc),
        .clear(clear), .rd_en(rd_en), .clkcnt(clkcnt), .clksav(clksav),
        .rd_valid(rd_valid), .rd_data(rd_data), .fifo_count(fifo_count),
        .overflow_cnt(overflow_cnt), .multi_cnt(multi_cnt)
    );

    always #5 clk = ~clk;

    int n_run = 0;
    int n_fail = 0;

    // Reference model state
    logic [CW-1:0] m_cnt, m_sav;
    logic [CW+1:0] m_q[$];
    logic [CW+1:0] m_rd;
    logic          m_rv;
    int            m_ovf, m_multi;

    task automatic model_reset();
        m_cnt = '0; m_sav = '0; m_q.delete(); m_rd = '0; m_rv = 0; m_ovf = 0; m_multi = 0;
    endtask

    task automatic try_push(input logic [CW+1:0] e);
        if (m_q.size() < DEPTH) m_q.push_back(e);
        else if (m_ovf < 65535) m_ovf++;
    endtask

    // Drive one cycle of inputs, clock it, advance the model, settle 1 time unit past the edge.
    task automatic step(input logic rm, input logic sc, input logic sv, input logic p,
                        input logic d, input logic n, input logic clr, input logic rd);
        logic [1:0] tg;
        int nf;
        runmode = rm; sync_clk = sc; save_clk = sv; pcoinc = p; dcoinc = d; ncoinc = n;
        clear = clr; rd_en = rd;
        @(posedge clk);
        nf = int'(p) + int'(d) + int'(n);
        tg = p ? 2'd1 : (d ? 2'd2 : 2'd3);
        if (clr) begin
            m_q.delete(); m_ovf = 0; m_multi = 0; m_rv = 0;
        end else begin
            m_rv = rd && (m_q.size() > 0);
            if (m_rv) m_rd = m_q.pop_front();
            if (rm && nf > 1 && m_multi < 65535) m_multi++;
`ifdef ROCSTAR_TS_SYNCSTAMP_EN
            if (sc) begin
                try_push({2'b00, m_cnt});
                if (rm && nf > 0 && m_ovf < 65535) m_ovf++;
            end else if (rm && nf > 0) try_push({tg, m_cnt});
`else
            if (rm && nf > 0) try_push({tg, m_cnt});
`endif
        end
        if (sv) m_sav = m_cnt;
        m_cnt = sc ? '0 : m_cnt + 1;
        #1;
    endtask

    task automatic idle_until(input logic [CW-1:0] target, input logic rm);
        for (int i = 0; i < 2000 && m_cnt != target; i++) step(rm, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_run++;
        if ({clkcnt, clksav, rd_valid, rd_data, fifo_count, overflow_cnt, multi_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: clkcnt=%0d clksav=%0d rv=%0b rd=%h cnt=%0d ovf=%0d mul=%0d (all 0 required)",
                     clkcnt, clksav, rd_valid, rd_data, fifo_count, overflow_cnt, multi_cnt);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_counter();
        repeat (100) step(0, 0, 0, 0, 0, 0, 0, 0);
        n_run++;
        if (clkcnt !== 48'd100) begin
            n_fail++; $display("FAIL clkcnt_100: got %0d want 100", clkcnt);
        end
        step(0, 1, 0, 0, 0, 0, 0, 0);
        n_run++;
        if (clkcnt !== 48'd0) begin
            n_fail++; $display("FAIL clkcnt_sync: got %0d want 0", clkcnt);
        end
    endtask

    task automatic test_save();
        idle_until(48'd500, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        n_run++;
        if (clksav !== 48'd500) begin
            n_fail++; $display("FAIL save_500: got %0d want 500", clksav);
        end
        idle_until(48'd700, 0);
        step(0, 1, 1, 0, 0, 0, 0, 0);
        n_run++;
        if (clksav !== 48'd700 || clkcnt !== 48'd0) begin
            n_fail++;
            $display("FAIL sync_save: clksav=%0d clkcnt=%0d want 700/0", clksav, clkcnt);
        end
    endtask

    task automatic test_capture();
        logic [CW+1:0] exp_e [3];
        exp_e[0] = {2'b01, 48'd10}; exp_e[1] = {2'b10, 48'd20}; exp_e[2] = {2'b11, 48'd30};
        step(1, 1, 0, 0, 0, 0, 0, 0);
        idle_until(48'd10, 1); step(1, 0, 0, 1, 0, 0, 0, 0);
        idle_until(48'd20, 1); step(1, 0, 0, 0, 1, 0, 0, 0);
        idle_until(48'd30, 1); step(1, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 0, 0, 0, 1);
            n_run++;
            if (rd_valid !== 1'b1 || rd_data !== exp_e[i]) begin
                n_fail++;
                $display("FAIL capture_read%0d: rv=%0b data=%h want rv=1 data=%h",
                         i, rd_valid, rd_data, exp_e[i]);
            end
        end
        step(1, 0, 0, 0, 0, 0, 0, 0);
        n_run++;
        if (rd_valid !== 1'b0 || rd_data !== exp_e[2]) begin
            n_fail++;
            $display("FAIL rd_hold: rv=%0b data=%h want rv=0 data=%h", rd_valid, rd_data, exp_e[2]);
        end
    endtask

    task automatic test_multi();
        step(1, 1, 0, 0, 0, 0, 0, 0);
        idle_until(48'd40, 1);
        step(1, 0, 0, 1, 0, 1, 0, 0);
        n_run++;
        if (fifo_count !== 5'd1 || multi_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL multi_flag: count=%0d multi=%0d want 1/1", fifo_count, multi_cnt);
        end
        step(1, 0, 0, 0, 0, 0, 0, 1);
        n_run++;
        if (rd_valid !== 1'b1 || rd_data !== {2'b01, 48'd40}) begin
            n_fail++;
            $display("FAIL multi_entry: rv=%0b data=%h want 1/%h", rd_valid, rd_data, {2'b01, 48'd40});
        end
    endtask

    task automatic test_overflow();
        logic [CW+1:0] oldest;
        repeat (DEPTH + 3) step(1, 0, 0, 1, 0, 0, 0, 0);
        n_run++;
        if (overflow_cnt !== 16'd3 || fifo_count !== 5'd16) begin
            n_fail++;
            $display("FAIL overflow: ovf=%0d count=%0d want 3/16", overflow_cnt, fifo_count);
        end
        oldest = m_q[0];
        step(1, 0, 0, 0, 1, 0, 0, 1);
        n_run++;
        if (fifo_count !== 5'd16 || rd_valid !== 1'b1 || rd_data !== oldest
            || overflow_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL push_pop_full: count=%0d rv=%0b data=%h ovf=%0d want 16/1/%h/3",
                     fifo_count, rd_valid, rd_data, overflow_cnt, oldest);
        end
    endtask

    task automatic test_clear();
        step(0, 0, 0, 0, 0, 0, 1, 0);
        repeat (5) step(1, 0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 1, 1);
        n_run++;
        if (fifo_count !== 5'd0 || overflow_cnt !== 16'd0 || multi_cnt !== 16'd0
            || rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clear: count=%0d ovf=%0d multi=%0d rv=%0b want 0/0/0/0",
                     fifo_count, overflow_cnt, multi_cnt, rd_valid);
        end
        step(1, 0, 0, 0, 0, 0, 0, 1);
        n_run++;
        if (rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL rd_empty: rv=%0b want 0", rd_valid);
        end
`ifdef ROCSTAR_TS_SYNCSTAMP_EN
        idle_until(48'd900, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        n_run++;
        if (rd_valid !== 1'b1 || rd_data !== {2'b00, 48'd900}) begin
            n_fail++;
            $display("FAIL sync_stamp: rv=%0b data=%h want 1/%h", rd_valid, rd_data, {2'b00, 48'd900});
        end
`endif
    endtask

    task automatic test_async_reset();
        repeat (4) step(1, 0, 0, 1, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        n_run++;
        if ({clkcnt, clksav, rd_valid, rd_data, fifo_count, overflow_cnt, multi_cnt} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: clkcnt=%0d cnt=%0d rv=%0b rd=%h (all 0 required)",
                     clkcnt, fifo_count, rd_valid, rd_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        step(1, 0, 0, 0, 0, 0, 0, 1);
        n_run++;
        if (rd_valid !== 1'b0 || fifo_count !== 5'd0 || clkcnt !== 48'd1) begin
            n_fail++;
            $display("FAIL post_reset: rv=%0b count=%0d clkcnt=%0d want 0/0/1",
                     rd_valid, fifo_count, clkcnt);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 7) != 0), ($urandom_range(0, 40) == 0),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 60) == 0), ($urandom_range(0, 2) == 0));
            n_run++;
            if (rd_valid !== m_rv || rd_data !== m_rd || fifo_count !== 5'(m_q.size())
                || overflow_cnt !== 16'(m_ovf) || multi_cnt !== 16'(m_multi)
                || clkcnt !== m_cnt || clksav !== m_sav) begin
                n_fail++;
                if (bad < 10)
                    $display("FAIL random_%0d: rv=%0b/%0b rd=%h/%h cnt=%0d/%0d ovf=%0d/%0d mul=%0d/%0d clk=%0d/%0d sav=%0d/%0d (got/want)",
                             i, rd_valid, m_rv, rd_data, m_rd, fifo_count, m_q.size(),
                             overflow_cnt, m_ovf, multi_cnt, m_multi, clkcnt, m_cnt, clksav, m_sav);
                bad++;
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_counter();
        test_save();
        test_capture();
        test_multi();
        test_overflow();
        test_clear();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
